// File: rtl/prach_hb1_interp_ch_if.sv
// Streaming bus for the PRACH half-band interpolator.
// It carries the TDM sample input and the interpolated output pair.
interface prach_hb1_interp_ch_if;
  logic signed [15:0] din_dq;
  logic               din_dv;
  logic        [7:0]  din_chn;
  logic               sync_in;
  logic signed [15:0] dout_dp1;
  logic signed [15:0] dout_dp2;
  logic               dout_dv;
  logic        [7:0]  dout_chn;
  logic               sync_out;
  logic               chn_err;

  modport master (
    output din_dq, din_dv, din_chn, sync_in,
    input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, chn_err
  );

  modport slave (
    input  din_dq, din_dv, din_chn, sync_in,
    output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, chn_err
  );
endinterface

// File: rtl/prach_hb1_interp_ch.sv
// 2x half-band interpolator for TDM-interleaved PRACH channels.
// Even phase: 4-tap FIR with gain 2. Odd phase: delayed center-tap sample.
module prach_hb1_interp_ch #(
  parameter int NumChannel = 16,
  parameter int Latency    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  prach_hb1_interp_ch_if.slave strm
);
  localparam int CoreStages  = 5;
  localparam int ExtraStages = (Latency > CoreStages) ? Latency - CoreStages : 0;
  localparam int LineLen     = 3 * NumChannel + 1;
  localparam logic [7:0] LastChn = 8'(NumChannel - 1);
  localparam logic signed [17:0] C0 = -18'sd4134;
  localparam logic signed [17:0] C1 = 18'sd36901;
  localparam logic signed [35:0] RoundHalf = 36'sd32768;

  typedef struct packed {
    logic       dv;
    logic [7:0] chn;
    logic       sync;
    logic       err;
  } side_t;

  typedef struct packed {
    side_t       side;
    logic [15:0] dp1;
    logic [15:0] dp2;
  } out_t;

  logic signed [15:0] line_q [LineLen];
  logic        [7:0]  expChn_q, expChn_d, expChnNow;
  logic               chnMiss;
  side_t              side_d;
  side_t              side_q [CoreStages-1];
  logic signed [16:0] preOuter_q, preInner_q;
  logic signed [15:0] center2_q, center3_q, center4_q;
  logic signed [34:0] prodOuter_q, prodInner_q;
  logic signed [35:0] acc_q;
  logic signed [19:0] accShift;
  logic signed [15:0] dp1Sat;
  out_t               stage5_d, stage5_q, outSel;

  // Shared history line: entries NumChannel apart hold the same channel's x[n-k].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LineLen; i++) line_q[i] <= '0;
    end else if (strm.din_dv) begin
      line_q[0] <= strm.din_dq;
      for (int i = 1; i < LineLen; i++) line_q[i] <= line_q[i-1];
    end
  end

  always_comb begin
    expChnNow = strm.sync_in ? 8'd0 : expChn_q;
    chnMiss   = strm.din_chn != expChnNow;
    expChn_d  = expChn_q;
    if (strm.din_dv) expChn_d = (strm.din_chn >= LastChn) ? 8'd0 : strm.din_chn + 8'd1;
    side_d = '{dv: strm.din_dv, chn: strm.din_chn, sync: strm.sync_in,
               err: strm.din_dv & chnMiss};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expChn_q <= '0;
      for (int i = 0; i < CoreStages - 1; i++) side_q[i] <= '0;
    end else begin
      expChn_q  <= expChn_d;
      side_q[0] <= side_d;
      for (int i = 1; i < CoreStages - 1; i++) side_q[i] <= side_q[i-1];
    end
  end

  // Rounding constant is folded into the accumulator so stage 5 is shift and clamp only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preOuter_q  <= '0;
      preInner_q  <= '0;
      center2_q   <= '0;
      prodOuter_q <= '0;
      prodInner_q <= '0;
      center3_q   <= '0;
      acc_q       <= '0;
      center4_q   <= '0;
      stage5_q    <= '0;
    end else begin
      preOuter_q  <= 17'(line_q[0]) + 17'(line_q[3*NumChannel]);
      preInner_q  <= 17'(line_q[NumChannel]) + 17'(line_q[2*NumChannel]);
      center2_q   <= line_q[NumChannel];
      prodOuter_q <= 35'(C0) * 35'(preOuter_q);
      prodInner_q <= 35'(C1) * 35'(preInner_q);
      center3_q   <= center2_q;
      acc_q       <= 36'(prodOuter_q) + 36'(prodInner_q) + RoundHalf;
      center4_q   <= center3_q;
      stage5_q    <= stage5_d;
    end
  end

  assign accShift = 20'(acc_q >>> 16);

  always_comb begin
    if (accShift > 20'sd32767)       dp1Sat = 16'sh7FFF;
    else if (accShift < -20'sd32768) dp1Sat = 16'sh8000;
    else                             dp1Sat = accShift[15:0];
    stage5_d = '{side: side_q[CoreStages-2], dp1: dp1Sat, dp2: center4_q};
  end

  if (ExtraStages == 0) begin : gDirect
    assign outSel = stage5_q;
  end else begin : gDelay
    out_t dly_q [ExtraStages];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < ExtraStages; i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= stage5_q;
        for (int i = 1; i < ExtraStages; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign outSel = dly_q[ExtraStages-1];
  end

  assign strm.dout_dp1 = outSel.dp1;
  assign strm.dout_dp2 = outSel.dp2;
  assign strm.dout_dv  = outSel.side.dv;
  assign strm.dout_chn = outSel.side.chn;
  assign strm.sync_out = outSel.side.sync;
  assign strm.chn_err  = outSel.side.err;
endmodule

// File: tb/tb_prach_hb1_interp_ch.sv
// Bench for prach_hb1_interp_ch: randomized TDM streams compared every cycle
// against a sample-history model, plus literal impulse/DC/saturation/order cases.
module tb_prach_hb1_interp_ch;
  localparam int N   = 16;
  localparam int Lat = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prach_hb1_interp_ch_if strm ();

  prach_hb1_interp_ch #(.NumChannel(N), .Latency(Lat)) dut (
    .clk (clk),
    .rst (rst),
    .strm(strm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int dp1;
    int dp2;
    int chn;
    bit sync;
    bit err;
  } exp_t;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   inCount  = 0;
  int   outCount = 0;
  exp_t expQ[$];
  int   hist[$];
  int   expCh = 0;
  int   logDp1[$];
  int   logDp2[$];
  int   logChn[$];
  bit   logErr[$];
  bit   logSync[$];
  int   impDp1[5]  = '{-1033, 9225, 9225, -1033, 0};
  int   impDp2[4]  = '{0, 16384, 0, 0};
  int   satIn[4]   = '{-32768, 32767, 32767, -32768};
  int   skipSeq[7] = '{0, 1, 2, 3, 4, 6, 7};
  int   syncSeq[7] = '{0, 1, 5, 2, 0, 1, 2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // x[n-k] of the current channel is the accepted sample N*k positions back.
  function automatic int tap(input int k);
    int idx = hist.size() - 1 - N * k;
    return (idx >= 0) ? hist[idx] : 0;
  endfunction

  function automatic int modelDp1(input int a, input int b, input int c, input int d);
    longint acc = longint'(-4134) * (a + d) + longint'(36901) * (b + c);
    longint y   = (acc + 32768) >>> 16;
    if (y > 32767)  return 32767;
    if (y < -32768) return -32768;
    return int'(y);
  endfunction

  initial begin : compare
    exp_t e;
    bit   want;
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("rst_dout_dv", strm.dout_dv, 0);
        checkOutput("rst_dout_dp1", strm.dout_dp1, 0);
        checkOutput("rst_dout_dp2", strm.dout_dp2, 0);
        checkOutput("rst_dout_chn", strm.dout_chn, 0);
        checkOutput("rst_sync_out", strm.sync_out, 0);
        checkOutput("rst_chn_err", strm.chn_err, 0);
        expQ.delete();
        hist.delete();
        expCh = 0;
      end else begin
        want = (expQ.size() > 0) && (expQ[0].due == cyc);
        checkOutput("dout_dv", strm.dout_dv, want);
        if (strm.dout_dv) begin
          outCount++;
          logDp1.push_back(int'(strm.dout_dp1));
          logDp2.push_back(int'(strm.dout_dp2));
          logChn.push_back(int'(strm.dout_chn));
          logErr.push_back(strm.chn_err);
          logSync.push_back(strm.sync_out);
        end
        if (want) begin
          e = expQ.pop_front();
          checkOutput("dout_dp1", strm.dout_dp1, e.dp1);
          checkOutput("dout_dp2", strm.dout_dp2, e.dp2);
          checkOutput("dout_chn", strm.dout_chn, e.chn);
          checkOutput("sync_out", strm.sync_out, e.sync);
          checkOutput("chn_err", strm.chn_err, e.err);
        end
        if (strm.din_dv) begin
          inCount++;
          hist.push_back(int'(strm.din_dq));
          e.due  = cyc + Lat;
          e.dp1  = modelDp1(tap(0), tap(1), tap(2), tap(3));
          e.dp2  = tap(1);
          e.chn  = int'(strm.din_chn);
          e.sync = strm.sync_in;
          e.err  = int'(strm.din_chn) != (strm.sync_in ? 0 : expCh);
          expCh  = (int'(strm.din_chn) + 1) % N;
          expQ.push_back(e);
        end
      end
    end
  end

  task automatic applyStimulus(input int chn, input int dq, input bit sync, input bit dv);
    @(posedge clk);
    #1;
    strm.din_chn = 8'(chn);
    strm.din_dq  = 16'(dq);
    strm.sync_in = sync;
    strm.din_dv  = dv;
  endtask

  task automatic sendSample(input int chn, input int dq, input bit sync, input int gapPct);
    while (int'($urandom_range(99)) < gapPct)
      applyStimulus(int'($urandom_range(255)), int'($urandom_range(65535)), 1'b0, 1'b0);
    applyStimulus(chn, dq, sync, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 1'b0, 1'b0);
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    strm.din_dv  = 1'b0;
    strm.sync_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clearLog();
    logDp1.delete();
    logDp2.delete();
    logChn.delete();
    logErr.delete();
    logSync.delete();
  endtask

  task automatic runImpulse(input int gapPct);
    for (int f = 0; f < 6; f++)
      for (int c = 0; c < N; c++)
        sendSample(c, (f == 0 && c == 3) ? 16384 : 0, c == 0, gapPct);
    idle(Lat + 3);
  endtask

  task automatic checkImpulse(input string tag);
    int k = 0;
    int nonzero = 0;
    foreach (logChn[i]) begin
      if (logChn[i] == 3) begin
        if (k < 5) checkOutput({tag, "_ch3_dp1"}, logDp1[i], impDp1[k]);
        if (k < 4) checkOutput({tag, "_ch3_dp2"}, logDp2[i], impDp2[k]);
        k++;
      end else if (logDp1[i] != 0 || logDp2[i] != 0) begin
        nonzero++;
      end
    end
    checkOutput({tag, "_ch3_count"}, k, 6);
    checkOutput({tag, "_others_nonzero"}, nonzero, 0);
  endtask

  initial begin : stimulus
    int inSnap;
    int outSnap;
    int k;
    int bad;
    int cnt;
    int errCnt;
    int errChn;
    int syncCnt;
    int chn;

    strm.din_dq  = '0;
    strm.din_dv  = 1'b0;
    strm.din_chn = '0;
    strm.sync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Random in-order frames with gaps.
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < N; c++)
        sendSample(c, int'($urandom_range(65535)) - 32768, c == 0, 25);

    // Reset while samples are in flight: none of them may emerge.
    for (int i = 0; i < 10; i++)
      sendSample(i, int'($urandom_range(65535)) - 32768, 1'b0, 0);
    doReset(2);
    outSnap = outCount;
    idle(Lat + 3);
    checkOutput("rst_discard_dv_count", outCount - outSnap, 0);

    clearLog();
    runImpulse(0);
    checkImpulse("impulse");

    doReset(2);
    clearLog();
    inSnap  = inCount;
    outSnap = outCount;
    runImpulse(30);
    checkImpulse("gap");
    checkOutput("gap_in_count", inCount - inSnap, 6 * N);
    checkOutput("gap_dv_count", outCount - outSnap, inCount - inSnap);

    doReset(2);
    clearLog();
    for (int f = 0; f < 5; f++)
      for (int c = 0; c < N; c++)
        sendSample(c, 32767, c == 0, 10);
    idle(Lat + 3);
    bad = 0;
    cnt = 0;
    for (int i = 3 * N; i < logDp1.size(); i++) begin
      cnt++;
      if (logDp1[i] != 32766 || logDp2[i] != 32767) bad++;
    end
    checkOutput("dc_count", cnt, 2 * N);
    checkOutput("dc_bad", bad, 0);

    doReset(2);
    clearLog();
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < N; c++)
        sendSample(c, (c == 5) ? satIn[f] : 0, c == 0, 0);
    idle(Lat + 3);
    k = 0;
    foreach (logChn[i]) begin
      if (logChn[i] == 5) begin
        k++;
        if (k == 4) begin
          checkOutput("sat_dp1", logDp1[i], 32767);
          checkOutput("sat_dp2", logDp2[i], 32767);
        end
      end
    end
    checkOutput("sat_ch5_count", k, 4);

    doReset(2);
    clearLog();
    foreach (skipSeq[i]) sendSample(skipSeq[i], i * 100, 1'b0, 0);
    idle(Lat + 3);
    errCnt = 0;
    errChn = -1;
    foreach (logErr[i]) if (logErr[i]) begin
      errCnt++;
      errChn = logChn[i];
    end
    checkOutput("skip_err_count", errCnt, 1);
    checkOutput("skip_err_chn", errChn, 6);
    checkOutput("skip_log_size", logChn.size(), 7);
    checkOutput("skip_ch7_err", logErr[6], 0);

    doReset(2);
    clearLog();
    foreach (syncSeq[i]) sendSample(syncSeq[i], -i * 50, i == 4, 0);
    idle(Lat + 3);
    errCnt  = 0;
    syncCnt = 0;
    foreach (logErr[i]) begin
      if (logErr[i]) errCnt++;
      if (logSync[i]) syncCnt++;
    end
    checkOutput("sync_log_size", logChn.size(), 7);
    checkOutput("sync_err_count", errCnt, 2);
    checkOutput("sync_ch0_chn", logChn[4], 0);
    checkOutput("sync_ch0_err", logErr[4], 0);
    checkOutput("sync_ch0_sync_out", logSync[4], 1);
    checkOutput("sync_out_count", syncCnt, 1);

    // Random stream with occasional misordered channels and sporadic sync.
    doReset(2);
    for (int f = 0; f < 6; f++)
      for (int c = 0; c < N; c++) begin
        chn = ($urandom_range(9) == 0) ? int'($urandom_range(N - 1)) : c;
        sendSample(chn, int'($urandom_range(65535)) - 32768,
                   (chn == 0) && ($urandom_range(1) == 1), 20);
      end
    idle(Lat + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prach_hb1_interp_ch.md
PRACH_HB1_INTERP_CH -- requirements
Module: prach_hb1_interp_ch

Interface
REQ-001 Parameter NumChannel, default 16, number of TDM channels interleaved on the input stream.
REQ-002 Parameter Latency, default 5, din_dv-to-dout_dv pipeline depth in clk cycles.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din_dq  input  16  signed input sample, one per channel slot.
REQ-006 din_dv  input  1  input sample valid.
REQ-007 din_chn  input  8  channel index of din_dq.
REQ-008 sync_in  input  1  frame marker, qualified by din_dv, marks channel 0.
REQ-009 dout_dp1  output  16  signed even-phase output y[2n], produced by the FIR phase.
REQ-010 dout_dp2  output  16  signed odd-phase output y[2n+1], produced by the center-tap phase.
REQ-011 dout_dv  output  1  output pair valid.
REQ-012 dout_chn  output  8  channel index of the output pair.
REQ-013 sync_out  output  1  sync_in delayed to align with the output pair.
REQ-014 chn_err  output  1  one-cycle pulse on a channel-order violation, aligned with dout_dv.

Function
REQ-015 The block SHALL be a 2x half-band interpolator: one input sample per channel yields one output pair (dp1, dp2) per channel.
REQ-016 Per-channel history x[n], x[n-1], x[n-2], x[n-3] SHALL advance only on din_dv; a shared shift line of 3*NumChannel+1 entries is acceptable.
REQ-017 With tap offsets 0, 16, 32, 48, a 49-entry shift line matches the default NumChannel of 16.
REQ-018 Coefficients SHALL be c0 = -4134 and c1 = 36901 (18-bit signed, Q17).
REQ-019 The FIR accumulator SHALL be acc = c0*(x[n]+x[n-3]) + c1*(x[n-1]+x[n-2]).
REQ-020 Pre-add widths SHALL be 17 bits, products 35 bits and acc 36 bits, all full precision with no intermediate truncation.
REQ-021 dout_dp1 SHALL equal sat16((acc + 2^15) >>> 16).
REQ-022 The shift is arithmetic, giving interpolation gain 2 with round-half-up.
REQ-023 sat16 SHALL clamp to [-32768, 32767].
REQ-024 dout_dp2 SHALL equal x[n-1] of the same channel, unscaled; this is center tap 0.5 times gain 2.
REQ-025 Output pair fields dp1, dp2, dout_chn and sync_out SHALL all correspond to the same input sample.
REQ-026 They SHALL appear exactly Latency cycles after that sample's din_dv.
REQ-027 dout_dv SHALL be din_dv delayed by Latency; every input valid produces exactly one output valid.
REQ-028 Gaps (din_dv low) SHALL not alter computed values; outputs equal the gapless case apart from timing.
REQ-029 Output data and chn_err are don't-care while dout_dv = 0; dout_chn and sync_out simply track the delay line.
REQ-030 An expected-channel counter SHALL start at 0 and increment on each din_dv, wrapping from NumChannel-1 to 0.
REQ-031 din_dv with sync_in=1 SHALL force the expected channel to 0 before the compare.
REQ-032 When din_dv=1 and din_chn differs from the expected channel, chn_err SHALL pulse with that sample's dout_dv.
REQ-033 After a mismatch, the counter SHALL resync to din_chn+1 (wrapped); the sample is still processed normally.
REQ-034 The datapath SHALL not stall or back-pressure; an input is accepted on every cycle with din_dv=1.

Reset
REQ-035 While rst=1, dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out and chn_err SHALL be 0.
REQ-036 While rst=1, all pipeline and valid stages SHALL be 0, all history entries SHALL be 0 and the expected-channel counter SHALL be 0.
REQ-037 Reset asserted mid-stream SHALL discard in-flight samples: no dout_dv for samples accepted before reset.
REQ-038 After release, the first output SHALL behave as if history were all zero.
REQ-039 The first din_dv may occur on the cycle after rst deasserts.

Verification
REQ-040 Reset: assert rst mid-stream -> all outputs 0 immediately, no dout_dv for pre-reset samples.
REQ-041 Reset: after release, zero history is confirmed by the impulse case in REQ-042.
REQ-042 Impulse: ch3 gets 16384 once, zeros elsewhere and after, 16 channels continuous -> ch3 dp1 = -1033, 9225, 9225, -1033, then 0.
REQ-043 Impulse: on the same ch3 samples, dp2 = 0, 16384, 0, 0; all other channels 0; latency 5 cycles.
REQ-044 DC: 32767 on all channels -> steady-state dp1 = 32766 and dp2 = 32767 on every channel.
REQ-045 Saturation: one channel fed -32768, 32767, 32767, -32768 -> fourth output dp1 = 32767 (clamped from 41034).
REQ-046 Gaps: random din_dv gaps on the impulse stimulus -> identical per-channel values, dout_dv count = din_dv count, 5-cycle latency per sample.
REQ-047 Channel order, skip: sequence 0..4,6 -> chn_err pulse on the ch6 output only, no pulse on the following ch7.
REQ-048 Channel order, sync: sync_in on a ch0 sample after misordering -> no chn_err, and sync_out aligned with the ch0 output.
